bits_stream_buffer: RTL
=======================

# bits_stream_buffer

Bit-level stream buffer between the instruction-memory controller and the BITS packet decoder FSM. It requests 128-bit instruction words with the active-low `mem_req_b`/`mem_ack_b` handshake and packs their valid bytes into a 256-bit MSB-first bit buffer. It serves variable-width fields of 1..16 bits to the decoder, and keeps a running consumed-bit count for length-type-0 subpacket tracking.

## Interface
- `BUF_BITS`, 256: bit buffer capacity; fixed at 2× word width.
- `FIELD_MAX`, 16: maximum field width per request.
- `clk`  in  1  clock.
- `resetB`  in  1  asynchronous, active-low reset.
- `mem_req_b`  out  1  active-low word request; registered; held low until ack.
- `mem_ack_b`  in  1  active-low, one-cycle; `instruction_word`/`instruction_valid_bytes` valid this cycle.
- `instruction_word`  in  128  word data, byte 15 = bits [127:120] = first in stream.
- `instruction_valid_bytes`  in  16  byte mask, contiguous ones from bit 15 down.
- `done_reading_memory`  in  1  high with (or after) final ack; no more words.
- `fld_req`  in  1  field request, active-high; held with `fld_len` stable until `fld_ack`.
- `fld_len`  in  5  requested width; legal 1..16.
- `fld_ack`  out  1  one-cycle pulse; `fld_data`/`fld_err` valid.
- `fld_data`  out  16  field, right-aligned, zero-extended; first stream bit is the MSB of the field.
- `fld_err`  out  1  with `fld_ack`: underflow or illegal length.
- `bits_avail`  out  9  registered buffer level, 0..256.
- `bits_consumed`  out  16  total bits delivered, wraps 65535→0.

## Operation
- Buffer: 256-bit register, stream bit 0 at [255]. Level L = number of valid bits, left-aligned.
- Memory FSM states: M_IDLE, M_REQ, M_DONE.
  - M_IDLE→M_REQ when registered L ≤ 128 and not done; `mem_req_b` goes 0 at the same edge.
  - M_REQ on `mem_ack_b`=0: append V = 8 × (count of leading ones in the valid mask) bits at position L, so that `buf[255-L -: V]` = `word[127 -: V]`. L += V.
  - From M_REQ, after the ack: next state is M_IDLE if `done_reading_memory`=0, else M_DONE. `mem_req_b` returns to 1 at that edge.
  - `done_reading_memory`=1 in any state sets M_DONE; M_DONE holds until reset with `mem_req_b`=1.
  - `mem_ack_b` is ignored outside M_REQ.
  - No overflow is possible: a request is only issued at L ≤ 128, and L never grows while waiting.
- Field service:
  - Acceptance: `fld_req`=1 and `fld_ack`=0 (registered). At most one field per 2 cycles; a request still high during the ack cycle is not re-accepted.
  - `fld_len`=0: ack with data 0, no consumption.
  - `fld_len` 17..31: ack with `fld_err`=1 and data 0.
  - `fld_len` ≤ L: data = `buf[255 -: fld_len]` right-aligned. Buffer shifts left by `fld_len`, L -= `fld_len`, and `bits_consumed` += `fld_len`.
  - `fld_len` > L and M_DONE: `fld_ack`=1, `fld_err`=1, data 0, L unchanged.
  - `fld_len` > L and not M_DONE: stall (no ack) until a refill makes L sufficient.
- Simultaneous accept and ack in one cycle: consume first, then append at L − `fld_len`. Next L = L − `fld_len` + V.

## Timing
- Reset values:
  - Outputs: `mem_req_b`=1, `fld_ack`=0, `fld_data`=0, `fld_err`=0, `bits_avail`=0, `bits_consumed`=0.
  - Internal: buffer=0, M_IDLE.
- First `mem_req_b`=0 appears at the first edge after `resetB` deasserts.
- Field latency: accepted in cycle n; `fld_ack`, `fld_data`, `fld_err`, `bits_avail` and `bits_consumed` update at the edge ending cycle n. `fld_ack` is high for exactly cycle n+1.
- Word latency: ack sampled at edge k; `bits_avail` reflects the append after edge k.
- `fld_data` and `fld_err` hold their values until the next ack.
- Reset mid-request, or with an outstanding memory request: all state clears immediately. `mem_req_b` goes 1 asynchronously; a pending `fld_ack` is not issued.

## Test plan
- Reset:
  - Stimulus: hold `resetB`=0, then release.
  - Response: all outputs at reset values while low; `mem_req_b`=0 one cycle after release.
- Literal packet:
  - Stimulus: ack with word `128'hD2FE28_00…`, mask `16'hE000`, done=1; then requests of len 3,3,5,5,5.
  - Response: data 6, 4, 0x17, 0x1E, 0x05; `bits_consumed`=21; `bits_avail`=3; FSM in M_DONE.
- Underflow:
  - Stimulus: continue with a len 16 request.
  - Response: `fld_ack`=1, `fld_err`=1, `fld_data`=0, `bits_avail`=3. len 20 also gives `fld_err`=1; len 0 gives data 0 with no error.
- Refill and straddle:
  - Stimulus: two full words (`16'hFFFF`), word0 all `0xAA` bytes and word1 all `0x55` bytes; consume 8×16 bits.
  - Response: `bits_avail` reaches 256, then 128, at which point `mem_req_b` falls; a len 16 request at bit offset 120 returns `16'hAA55`.
- Simultaneous events:
  - Stimulus: at L=128, a field is accepted (len 5) in the same cycle the ack arrives (V=128).
  - Response: next `bits_avail`=251 and the stream order is preserved.
- Stall:
  - Stimulus: L=2, memory not done, request len 8.
  - Response: no `fld_ack` until the refill ack. `fld_ack` then comes on the cycle after acceptance, with the correct 8 bits spanning the old and new data.

Source files
------------

// File: rtl/bits_stream_buffer.sv
`default_nettype none
// bits_stream_buffer: packs 128-bit instruction words into a 256-bit MSB-first bit
// buffer and serves 1..16-bit fields to the packet decoder. Revision 1.0
module bits_stream_buffer #(
  parameter int BUF_BITS  = 256,
  parameter int FIELD_MAX = 16
) (
  input  logic                              clk,
  input  logic                              resetB,
  output logic                              mem_req_b,
  input  logic                              mem_ack_b,
  input  logic [BUF_BITS/2-1:0]             instruction_word,
  input  logic [BUF_BITS/16-1:0]            instruction_valid_bytes,
  input  logic                              done_reading_memory,
  input  logic                              fld_req,
  input  logic [4:0]                        fld_len,
  output logic                              fld_ack,
  output logic [FIELD_MAX-1:0]              fld_data,
  output logic                              fld_err,
  output logic [$clog2(BUF_BITS+1)-1:0]     bits_avail,
  output logic [15:0]                       bits_consumed
);

  localparam int         WORD_BITS = BUF_BITS / 2;
  localparam int         BYTES     = WORD_BITS / 8;
  localparam int         LVL_W     = $clog2(BUF_BITS + 1);
  localparam logic [4:0] LEN_MAX   = 5'(FIELD_MAX);

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_REQ  = 2'd1,
    M_DONE = 2'd2
  } mem_state_t;

  mem_state_t               state, state_nxt;
  logic                     req_b_nxt;

  logic [BUF_BITS-1:0]      bit_buf, buf_nxt, shifted, appended;
  logic [WORD_BITS-1:0]     word_mask;
  logic [LVL_W-1:0]         app_cnt, app_bits, len_ext, take_len, level_mid, level_nxt;
  logic                     run, ack_in, accept, len_bad, short_buf, do_ack, do_take;
  logic [4:0]               fld_shift;
  logic [FIELD_MAX-1:0]     field_val, data_nxt;

  // Memory request FSM
  always_ff @(posedge clk or negedge resetB) begin
    if (!resetB) begin
      state     <= M_IDLE;
      mem_req_b <= 1'b1;
    end else begin
      state     <= state_nxt;
      mem_req_b <= req_b_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_b_nxt = 1'b1;
    case (state)
      M_IDLE:  if (bits_avail <= LVL_W'(WORD_BITS)) state_nxt = M_REQ;
      M_REQ:   if (!mem_ack_b) state_nxt = M_IDLE;
      M_DONE:  state_nxt = M_DONE;
      default: state_nxt = M_IDLE;
    endcase
    if (done_reading_memory) state_nxt = M_DONE;
    req_b_nxt = (state_nxt != M_REQ);
  end

  // Appended width: 8 bits per leading valid byte of the mask
  always_comb begin
    app_cnt = '0;
    run     = 1'b1;
    for (int i = BYTES - 1; i >= 0; i--) begin
      run     = run & instruction_valid_bytes[i];
      app_cnt = app_cnt + LVL_W'(run);
    end
    app_bits  = app_cnt << 3;
    word_mask = ~({WORD_BITS{1'b1}} >> app_bits);
  end

  always_comb begin
    ack_in    = (state == M_REQ) && !mem_ack_b;
    accept    = fld_req && !fld_ack;
    len_ext   = LVL_W'(fld_len);
    len_bad   = fld_len > LEN_MAX;
    short_buf = len_ext > bits_avail;
    do_ack    = accept && (len_bad || !short_buf || state == M_DONE);
    do_take   = accept && !len_bad && !short_buf;
    take_len  = do_take ? len_ext : '0;
    fld_shift = LEN_MAX - fld_len;
    field_val = bit_buf[BUF_BITS-1 -: FIELD_MAX] >> fld_shift;
    data_nxt  = do_take ? field_val : '0;
    // Consume first, then the new word lands right after what remains
    level_mid = bits_avail - take_len;
    shifted   = bit_buf << take_len;
    appended  = {instruction_word & word_mask, {WORD_BITS{1'b0}}} >> level_mid;
    buf_nxt   = ack_in ? (shifted | appended) : shifted;
    level_nxt = ack_in ? (level_mid + app_bits) : level_mid;
  end

  always_ff @(posedge clk or negedge resetB) begin
    if (!resetB) begin
      bit_buf       <= '0;
      bits_avail    <= '0;
      bits_consumed <= '0;
      fld_ack       <= 1'b0;
      fld_data      <= '0;
      fld_err       <= 1'b0;
    end else begin
      bit_buf       <= buf_nxt;
      bits_avail    <= level_nxt;
      bits_consumed <= bits_consumed + 16'(take_len);
      fld_ack       <= do_ack;
      if (do_ack) begin
        fld_data <= data_nxt;
        fld_err  <= len_bad || short_buf;
      end
    end
  end

endmodule
`default_nettype wire
